// File: rtl/config_bus_pkg.sv
// Shared definitions for the configuration bus master: state encoding,
// bus width and the default idle address.
package config_bus_pkg;

  localparam int unsigned BUS_WIDTH = 32;
  localparam logic [BUS_WIDTH-1:0] ADDRESS_IDLE_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    TURN,
    RESP
  } state_e;

  // Counter reload value: the TURN state lasts (load + 1) cycles, and a
  // request for zero turnaround cycles still gets one.
  function automatic logic [3:0] turn_load(input int unsigned cycles);
    if (cycles == 0) begin
      return 4'd0;
    end else if (cycles > 16) begin
      return 4'hF;
    end else begin
      return 4'(cycles - 1);
    end
  endfunction

endpackage

// File: rtl/config_bus_master.sv
// Single-outstanding configuration bus master: SETUP/ACCESS strobe sequence
// on a shared tristate data bus, programmable turnaround, then a response.
module config_bus_master
  import config_bus_pkg::*;
#(
  parameter int unsigned           TURNAROUND_CYCLES = 1,
  parameter logic [BUS_WIDTH-1:0]  ADDRESS_IDLE      = ADDRESS_IDLE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [BUS_WIDTH-1:0] req_address,
  input  logic [BUS_WIDTH-1:0] req_writeData,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BUS_WIDTH-1:0] rsp_readData,
  output logic                 busy,
  output logic                 we,
  output logic                 oe,
  output logic [BUS_WIDTH-1:0] interfaceAddress,
  inout  wire  [BUS_WIDTH-1:0] interfaceData
);

  localparam logic [3:0] TURN_LOAD = turn_load(TURNAROUND_CYCLES);

  state_e               state_q, state_d;
  logic                 write_q, write_d;
  logic [BUS_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 drive_en_q, drive_en_d;

  always_comb begin
    state_d          = state_q;
    write_d          = write_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    rdata_d          = rdata_q;
    cnt_d            = cnt_q;
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    we               = 1'b0;
    oe               = 1'b0;
    interfaceAddress = ADDRESS_IDLE;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_address;
          wdata_d = req_writeData;
          rdata_d = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        interfaceAddress = addr_q;
        state_d          = ACCESS;
      end
      ACCESS: begin
        interfaceAddress = addr_q;
        we               = write_q;
        oe               = ~write_q;
        // Read data is taken from the bus at the edge that closes ACCESS.
        if (!write_q) begin
          rdata_d = interfaceData;
        end
        cnt_d   = TURN_LOAD;
        state_d = TURN;
      end
      TURN: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Drive enable follows the state being entered so the flop is exactly
    // aligned with SETUP/ACCESS of a write.
    drive_en_d = write_d && ((state_d == SETUP) || (state_d == ACCESS));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      drive_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      drive_en_q <= drive_en_d;
    end
  end

  assign interfaceData = drive_en_q ? wdata_q : 'z;
  assign rsp_readData  = rdata_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_config_bus_master.sv
// Bench for config_bus_master: a 16-word responder on the shared bus, a
// high-level memory model for expected reads, and per-feature scenario tasks.
module tb_config_bus_master;

  localparam int unsigned TURN_CYC  = 3;
  localparam int unsigned EXP_LAT   = 3 + TURN_CYC;
  localparam logic [31:0] ADDR_IDLE = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, rsp_ready;
  logic [31:0] req_address, req_writeData;
  logic        req_ready, rsp_valid, busy, we, oe;
  logic [31:0] rsp_readData, interfaceAddress;
  wire  [31:0] bus_w;

  logic        req_valid0, req_write0, rsp_ready0;
  logic [31:0] req_address0, req_writeData0;
  logic        req_ready0, rsp_valid0, busy0, we0, oe0;
  logic [31:0] rsp_readData0, interfaceAddress0;
  wire  [31:0] bus0_w;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] dev_mem [16] = '{default: 32'h0};
  logic [31:0] model_mem [16];

  always #5 clk = ~clk;

  pulldown pd_bus (bus_w);
  pulldown pd_bus0 (bus0_w);

  config_bus_master #(.TURNAROUND_CYCLES(TURN_CYC), .ADDRESS_IDLE(ADDR_IDLE)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_writeData(req_writeData),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_readData(rsp_readData),
    .busy(busy), .we(we), .oe(oe),
    .interfaceAddress(interfaceAddress), .interfaceData(bus_w)
  );

  config_bus_master #(.TURNAROUND_CYCLES(0), .ADDRESS_IDLE(ADDR_IDLE)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_address(req_address0), .req_writeData(req_writeData0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_readData(rsp_readData0),
    .busy(busy0), .we(we0), .oe(oe0),
    .interfaceAddress(interfaceAddress0), .interfaceData(bus0_w)
  );

  function automatic logic dev_hit(input logic [31:0] a);
    return (a < 32'h40) && (a[1:0] == 2'b00);
  endfunction

  // Responder: 16 words at 0x00..0x3C, silent elsewhere (bus falls to the pull-down).
  assign bus_w = (oe && dev_hit(interfaceAddress)) ? dev_mem[interfaceAddress[5:2]] : 'z;

  always @(posedge clk) begin
    if (we && dev_hit(interfaceAddress)) dev_mem[interfaceAddress[5:2]] <= bus_w;
  end

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    if (a >= 32'h40 || a[1:0] != 2'b00) return 32'h0;
    return model_mem[a[5:2]];
  endfunction

  // Bus protocol monitor on the main instance.
  always @(negedge clk) begin
    n_checks++;
    if (we && oe) begin
      n_fail++;
      $display("FAIL strobe_overlap we=%b oe=%b required not both high", we, oe);
    end
    if (interfaceAddress == ADDR_IDLE) begin
      n_checks++;
      if (bus_w !== 32'h0) begin
        n_fail++;
        $display("FAIL bus_released_when_idle bus=%h required 00000000", bus_w);
      end
    end
    if (oe) begin
      n_checks++;
      if (bus_w !== (dev_hit(interfaceAddress) ? dev_mem[interfaceAddress[5:2]] : 32'h0)) begin
        n_fail++;
        $display("FAIL bus_no_drive_on_read bus=%h required %h", bus_w,
                 dev_hit(interfaceAddress) ? dev_mem[interfaceAddress[5:2]] : 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one request from a negedge and returns at a negedge after the handshake.
  task automatic drive_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int unsigned hold, output logic [31:0] rdata,
                           output int unsigned lat, output bit ok);
    int unsigned guard;
    ok = 1'b0; lat = 0; rdata = '0; guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    if (req_ready !== 1'b1) return;
    req_valid = 1'b1; req_write = w; req_address = a; req_writeData = d;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom_range(0, 1));
    req_address = $urandom; req_writeData = $urandom;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    if (rsp_valid !== 1'b1) return;
    rdata = rsp_readData;
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    int unsigned g;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_writeData = '0;
    rsp_ready = 1'b0;
    req_valid0 = 1'b0; req_write0 = 1'b0; req_address0 = '0; req_writeData0 = '0;
    rsp_ready0 = 1'b0;
    for (int unsigned i = 0; i < 16; i++) model_mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b want=0", we); end
    n_checks++; if (oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got=%b want=0", oe); end
    n_checks++; if (interfaceAddress !== ADDR_IDLE) begin n_fail++; $display("FAIL reset_addr got=%h want=%h", interfaceAddress, ADDR_IDLE); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    n_checks++; if (rsp_readData !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h want=0", rsp_readData); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    n_checks++; if (bus_w !== 32'h0) begin n_fail++; $display("FAIL reset_bus got=%h want=0", bus_w); end
    // Request presented while reset releases: taken on the first edge.
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h20;
    rst = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL first_edge_accept busy=%b req_ready=%b want busy=1 req_ready=0", busy, req_ready); end
    g = 1;
    while (rsp_valid !== 1'b1 && g < 40) begin @(negedge clk); g++; end
    n_checks++; if (g != EXP_LAT) begin n_fail++; $display("FAIL first_latency got=%0d want=%0d", g, EXP_LAT); end
    n_checks++; if (rsp_readData !== exp_read(32'h20)) begin n_fail++; $display("FAIL first_read got=%h want=%h", rsp_readData, exp_read(32'h20)); end
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; int unsigned lat; bit ok;
    drive_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 0, rd, lat, ok);
    model_mem[4] = 32'hDEAD_BEEF;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wr_handshake got=timeout want=response"); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL wr_rdata got=%h want=00000000", rd); end
    n_checks++; if (lat != EXP_LAT) begin n_fail++; $display("FAIL wr_latency got=%0d want=%0d", lat, EXP_LAT); end
    drive_txn(1'b0, 32'h10, 32'h0, 1, rd, lat, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rd_handshake got=timeout want=response"); end
    n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data got=%h want=deadbeef", rd); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; int unsigned lat; bit ok;
    drive_txn(1'b0, 32'h44, 32'h0, 0, rd, lat, ok);
    n_checks++; if (!ok || rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_read ok=%0d got=%h want=00000000", ok, rd); end
    n_checks++; if ($isunknown({we, oe})) begin n_fail++; $display("FAIL strobe_known got=%b%b want=known", we, oe); end
  endtask

  task automatic test_latency();
    logic [15:0] oe_mask; int unsigned first;
    oe_mask = '0; first = 0;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL lat_ready got=%b want=1", req_ready); end
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h10;
    for (int unsigned j = 1; j <= 9; j++) begin
      @(negedge clk);
      if (j == 1) req_valid = 1'b0;
      if (oe === 1'b1) oe_mask[j] = 1'b1;
      if (rsp_valid === 1'b1 && first == 0) first = j;
    end
    n_checks++; if (oe_mask !== 16'h0004) begin n_fail++; $display("FAIL oe_window got=%h want=0004", oe_mask); end
    n_checks++; if (first != EXP_LAT) begin n_fail++; $display("FAIL rsp_rise_cycle got=%0d want=%0d", first, EXP_LAT); end
    n_checks++; if (rsp_readData !== exp_read(32'h10)) begin n_fail++; $display("FAIL lat_data got=%h want=%h", rsp_readData, exp_read(32'h10)); end
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] cap, rd; int unsigned g, lat; bit ok;
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    g = 1;
    while (rsp_valid !== 1'b1 && g < 40) begin @(negedge clk); g++; end
    cap = rsp_readData;
    n_checks++; if (cap !== exp_read(32'h10)) begin n_fail++; $display("FAIL bp_data got=%h want=%h", cap, exp_read(32'h10)); end
    req_valid = 1'b1; req_write = 1'b1; req_address = 32'h14; req_writeData = 32'h0BAD_0BAD;
    for (int unsigned k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_readData !== cap || req_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold_%0d valid=%b data=%h ready=%b busy=%b want 1 %h 0 1", k, rsp_valid, rsp_readData, req_ready, busy, cap);
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got=%b want=0", rsp_valid); end
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_req busy=%b want=0", busy); end
    drive_txn(1'b0, 32'h14, 32'h0, 0, rd, lat, ok);
    n_checks++; if (!ok || rd !== exp_read(32'h14)) begin n_fail++; $display("FAIL bp_no_write ok=%0d got=%h want=%h", ok, rd, exp_read(32'h14)); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; int unsigned lat; bit ok; bit seen;
    req_valid = 1'b1; req_write = 1'b1; req_address = 32'h10; req_writeData = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL abort_in_access we=%b want=1", we); end
    #1 rst = 1'b0;
    #1;
    n_checks++; if (we !== 1'b0 || oe !== 1'b0) begin n_fail++; $display("FAIL abort_strobe we=%b oe=%b want 0 0", we, oe); end
    n_checks++; if (busy !== 1'b0 || interfaceAddress !== ADDR_IDLE) begin n_fail++; $display("FAIL abort_state busy=%b addr=%h want 0 %h", busy, interfaceAddress, ADDR_IDLE); end
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (rsp_valid !== 1'b0) seen = 1'b1; end
    n_checks++; if (seen) begin n_fail++; $display("FAIL abort_no_response got=rsp_valid want=none"); end
    drive_txn(1'b0, 32'h10, 32'h0, 0, rd, lat, ok);
    n_checks++; if (!ok || rd !== exp_read(32'h10)) begin n_fail++; $display("FAIL abort_reg_kept ok=%0d got=%h want=%h", ok, rd, exp_read(32'h10)); end
  endtask

  task automatic test_turn_zero();
    int unsigned first, oe_at; bit we_seen;
    first = 0; oe_at = 0; we_seen = 1'b0;
    n_checks++; if (req_ready0 !== 1'b1) begin n_fail++; $display("FAIL t0_ready got=%b want=1", req_ready0); end
    req_valid0 = 1'b1; req_write0 = 1'b0; req_address0 = 32'h44; req_writeData0 = $urandom;
    for (int unsigned j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j == 1) req_valid0 = 1'b0;
      if (oe0 === 1'b1 && oe_at == 0) oe_at = j;
      if (we0 === 1'b1) we_seen = 1'b1;
      if (rsp_valid0 === 1'b1 && first == 0) first = j;
    end
    n_checks++; if (first != 4) begin n_fail++; $display("FAIL t0_latency got=%0d want=4", first); end
    n_checks++; if (oe_at != 2 || we_seen) begin n_fail++; $display("FAIL t0_strobes oe_at=%0d we_seen=%0d want 2 0", oe_at, we_seen); end
    n_checks++; if (rsp_readData0 !== 32'h0) begin n_fail++; $display("FAIL t0_data got=%h want=0", rsp_readData0); end
    rsp_ready0 = 1'b1; @(negedge clk); rsp_ready0 = 1'b0;
    n_checks++; if (busy0 !== 1'b0 || interfaceAddress0 !== ADDR_IDLE || bus0_w !== 32'h0) begin
      n_fail++; $display("FAIL t0_idle busy=%b addr=%h bus=%h want 0 %h 0", busy0, interfaceAddress0, bus0_w, ADDR_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d, rd, want; logic w; int unsigned lat; bit ok;
    for (int unsigned i = 0; i < 100; i++) begin
      w = 1'($urandom_range(0, 1));
      a = {25'h0, 5'($urandom_range(0, 31)), 2'b00};
      d = $urandom;
      want = w ? 32'h0 : exp_read(a);
      drive_txn(w, a, d, $urandom_range(0, 2), rd, lat, ok);
      if (w && dev_hit(a)) model_mem[a[5:2]] = d;
      n_checks++;
      if (!ok || rd !== want || lat != EXP_LAT) begin
        n_fail++;
        $display("FAIL b2b_%0d w=%b addr=%h ok=%0d got=%h lat=%0d want=%h lat=%0d", i, w, a, ok, rd, lat, want, EXP_LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_unmapped();
    test_latency();
    test_backpressure();
    test_reset_abort();
    test_turn_zero();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
